// File: rtl/vsync_mode_detect.sv
// vsync_mode_detect: counts hsync lines between vsync events, classifies the
// video mode (PAL / NTSC / mono), detects interlace and reports a debounced mode.
module vsync_mode_detect #(
   parameter int unsigned STABLE_FRAMES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hsync_n,
   input  logic       vsync_n,
   output logic [9:0] lines,
   output logic [1:0] mode,
   output logic       interlace,
   output logic       valid,
   output logic       frame_stb
);

   localparam int unsigned CNT_W  = 10;
   localparam int unsigned STAB_W = 3;

   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(1023);
   localparam logic [STAB_W-1:0] STAB_TGT = STAB_W'(STABLE_FRAMES);

   localparam logic [1:0] CLS_UNK  = 2'b00;
   localparam logic [1:0] CLS_PAL  = 2'b01;
   localparam logic [1:0] CLS_NTSC = 2'b10;
   localparam logic [1:0] CLS_MONO = 2'b11;

   // Line-count to mode classification
   function automatic logic [1:0] classify(input logic [CNT_W-1:0] n);
      logic [1:0] c;
      c = CLS_UNK;
      if (n >= CNT_W'(311) && n <= CNT_W'(314)) c = CLS_PAL;
      if (n >= CNT_W'(261) && n <= CNT_W'(264)) c = CLS_NTSC;
      if (n >= CNT_W'(500) && n <= CNT_W'(502)) c = CLS_MONO;
      return c;
   endfunction

   // Synchroniser and edge registers, idle high
   logic hs_meta_q, hs_sync_q, hs_dly_q;
   logic vs_meta_q, vs_sync_q, vs_dly_q;

   // Two-flop synchroniser plus edge register for both sync inputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hs_meta_q <= 1'b1;
         hs_sync_q <= 1'b1;
         hs_dly_q  <= 1'b1;
         vs_meta_q <= 1'b1;
         vs_sync_q <= 1'b1;
         vs_dly_q  <= 1'b1;
      end else begin
         hs_meta_q <= hsync_n;
         hs_sync_q <= hs_meta_q;
         hs_dly_q  <= hs_sync_q;
         vs_meta_q <= vsync_n;
         vs_sync_q <= vs_meta_q;
         vs_dly_q  <= vs_sync_q;
      end
   end

   logic h_ev_c, v_ev_c;
   assign h_ev_c = hs_dly_q & ~hs_sync_q;
   assign v_ev_c = vs_dly_q & ~vs_sync_q;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  lines_q, lines_d;
   logic [CNT_W-1:0]  prev_lines_q, prev_lines_d;
   logic [1:0]        mode_q, mode_d;
   logic [1:0]        prev_cls_q, prev_cls_d;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic              valid_q, valid_d;
   logic              interlace_q, interlace_d;
   logic              stb_q, stb_d;

   logic [1:0]        cls_c;
   logic              same_c;
   logic [STAB_W-1:0] stab_inc_c;
   logic [STAB_W-1:0] stab_new_c;
   logic signed [CNT_W:0] diff_c;

   // Next-state: frame end, line counting and timeout
   always_comb begin
      cnt_d        = cnt_q;
      lines_d      = lines_q;
      prev_lines_d = prev_lines_q;
      mode_d       = mode_q;
      prev_cls_d   = prev_cls_q;
      stab_d       = stab_q;
      valid_d      = valid_q;
      interlace_d  = interlace_q;
      stb_d        = 1'b0;

      cls_c      = classify(cnt_q);
      same_c     = (cls_c == prev_cls_q);
      stab_inc_c = (stab_q >= STAB_TGT) ? STAB_TGT : stab_q + STAB_W'(1);
      stab_new_c = same_c ? stab_inc_c : STAB_W'(1);
      diff_c     = $signed({1'b0, cnt_q}) - $signed({1'b0, prev_lines_q});

      if (v_ev_c) begin
         // frame end takes priority over a coincident timeout
         lines_d      = cnt_q;
         cnt_d        = h_ev_c ? CNT_W'(1) : CNT_W'(0);
         stb_d        = 1'b1;
         stab_d       = stab_new_c;
         prev_cls_d   = cls_c;
         prev_lines_d = cnt_q;
         interlace_d  = same_c && (cls_c != CLS_UNK) &&
                        ((diff_c == 11'sd1) || (diff_c == -11'sd1));
         if (stab_new_c >= STAB_TGT) begin
            mode_d  = cls_c;
            valid_d = (cls_c != CLS_UNK);
         end else if (cls_c != mode_q) begin
            valid_d = 1'b0;
         end
      end else if (h_ev_c && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_MAX - CNT_W'(1)) begin
            // no vsync within a full counter range: drop the lock
            mode_d      = CLS_UNK;
            valid_d     = 1'b0;
            interlace_d = 1'b0;
            stab_d      = '0;
            prev_cls_d  = CLS_UNK;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         lines_q      <= '0;
         prev_lines_q <= '0;
         mode_q       <= CLS_UNK;
         prev_cls_q   <= CLS_UNK;
         stab_q       <= '0;
         valid_q      <= 1'b0;
         interlace_q  <= 1'b0;
         stb_q        <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         lines_q      <= lines_d;
         prev_lines_q <= prev_lines_d;
         mode_q       <= mode_d;
         prev_cls_q   <= prev_cls_d;
         stab_q       <= stab_d;
         valid_q      <= valid_d;
         interlace_q  <= interlace_d;
         stb_q        <= stb_d;
      end
   end

   assign lines     = lines_q;
   assign mode      = mode_q;
   assign interlace = interlace_q;
   assign valid     = valid_q;
   assign frame_stb = stb_q;

endmodule
